uart_rx: RTL and testbench

//  Serial 8N1 receiver; consumer of the uart_tx line driven by top.

---
 rtl/uart_rx.sv | 152 +++++++++++++++
 tb/tb_uart_rx.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 serial receiver: double-flop synchroniser, mid-bit sampling FSM and a
// one-entry valid/ready holding register with frame-error and overrun pulses.
module uart_rx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e         state_q;
  logic           sync1_q;
  logic           rx_s_q;
  logic           rx_prev_q;
  logic [CW-1:0]  cnt_q;
  logic [2:0]     idx_q;
  logic [7:0]     shift_q;
  logic [7:0]     data_q;
  logic           valid_q;
  logic           busy_q;
  logic           ferr_q;
  logic           ovr_q;

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

  // Synchroniser chain plus one-cycle history used for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= rx;
      rx_s_q    <= sync1_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // Receive FSM, shift register and holding register with status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
      if (valid_q && out_ready) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          // Only a genuine high-to-low transition arms; a line stuck low does not.
          if (rx_prev_q && !rx_s_q) begin
            state_q <= START;
            cnt_q   <= CNT_ZERO;
            busy_q  <= 1'b1;
          end
        end

        START: begin
          if (cnt_q == CNT_HALF) begin
            if (!rx_s_q) begin
              state_q <= DATA;
              cnt_q   <= CNT_ZERO;
              idx_q   <= 3'd0;
            end else begin
              state_q <= IDLE;
              cnt_q   <= CNT_ZERO;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        DATA: begin
          if (cnt_q == CNT_LAST) begin
            shift_q <= {rx_s_q, shift_q[7:1]};
            cnt_q   <= CNT_ZERO;
            idx_q   <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              state_q <= STOP;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        STOP: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
            busy_q  <= 1'b0;
            if (rx_s_q) begin
              // A same-cycle handshake frees the slot, so the new byte may load.
              if (!valid_q || out_ready) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                ovr_q <= 1'b1;
              end
            end else begin
              ferr_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        default: begin
          state_q <= IDLE;
          cnt_q   <= CNT_ZERO;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames
// compared against a frame-level reference queue.
module tb_uart_rx;

  localparam int CPB        = 4;
  localparam int HALF       = CPB / 2;
  localparam int LAT        = 3 + HALF + 9 * CPB;
  localparam int BUSY_FRAME = HALF + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] got_q[$];
  int fe_cnt = 0;
  int ov_cnt = 0;
  int busy_cnt = 0;
  int valid_cnt = 0;
  int both_cnt = 0;
  int rise_cyc = -1;
  logic prev_valid = 1'b0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (frame_err) fe_cnt = fe_cnt + 1;
      if (overrun) ov_cnt = ov_cnt + 1;
      if (frame_err && overrun) both_cnt = both_cnt + 1;
      if (busy) busy_cnt = busy_cnt + 1;
      if (out_valid) valid_cnt = valid_cnt + 1;
      if (out_valid && !prev_valid) rise_cyc = cyc;
    end
    prev_valid = out_valid;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive the first nslots line slots (start, 8 data LSB first, stop); t0 is the start edge.
  task automatic drive_frame(input logic [7:0] b, input logic stop, input int nslots,
                             output int t0);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    t0 = cyc;
    for (int i = 0; i < nslots; i++) begin
      rx = bits[i];
      idle(CPB);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rx = i[0];
      idle(1);
      checks++;
      if ({out_data, out_valid, busy, frame_err, overrun} !== 12'h000) begin
        errors++;
        $display("FAIL reset_hold: got data=%h v=%b busy=%b fe=%b ov=%b, want all 0",
                 out_data, out_valid, busy, frame_err, overrun);
      end
    end
    rx = 1'b1;
    idle(2);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      idle(1);
      checks++;
      if ({out_data, out_valid, busy, frame_err, overrun} !== 12'h000) begin
        errors++;
        $display("FAIL reset_idle: cycle %0d got data=%h v=%b busy=%b fe=%b ov=%b, want all 0",
                 i, out_data, out_valid, busy, frame_err, overrun);
      end
    end
  endtask

  task automatic test_frame_a5();
    int t0, base, bc0, vc0;
    out_ready = 1'b1;
    base = got_q.size();
    bc0 = busy_cnt;
    vc0 = valid_cnt;
    drive_frame(8'hA5, 1'b1, 10, t0);
    idle(6);
    checks++;
    if (got_q.size() !== base + 1) begin
      errors++;
      $display("FAIL a5_count: got %0d bytes, want 1", got_q.size() - base);
    end else begin
      checks++;
      if (got_q[base] !== 8'hA5) begin
        errors++;
        $display("FAIL a5_data: got %h, want a5", got_q[base]);
      end
    end
    checks++;
    if (rise_cyc - t0 !== LAT) begin
      errors++;
      $display("FAIL a5_latency: got %0d, want %0d", rise_cyc - t0, LAT);
    end
    checks++;
    if (valid_cnt - vc0 !== 1) begin
      errors++;
      $display("FAIL a5_valid_width: got %0d cycles, want 1", valid_cnt - vc0);
    end
    checks++;
    if (busy_cnt - bc0 !== BUSY_FRAME) begin
      errors++;
      $display("FAIL a5_busy_cycles: got %0d, want %0d", busy_cnt - bc0, BUSY_FRAME);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL a5_busy_after: got %b, want 0", busy);
    end
  endtask

  task automatic test_glitch();
    int bc0, vc0, fe0;
    bc0 = busy_cnt;
    vc0 = valid_cnt;
    fe0 = fe_cnt;
    rx = 1'b0;
    idle(1);
    rx = 1'b1;
    idle(12);
    checks++;
    if (busy_cnt - bc0 !== HALF) begin
      errors++;
      $display("FAIL glitch_busy: got %0d cycles, want %0d", busy_cnt - bc0, HALF);
    end
    checks++;
    if ((valid_cnt - vc0 !== 0) || (fe_cnt - fe0 !== 0)) begin
      errors++;
      $display("FAIL glitch_quiet: got valid=%0d fe=%0d, want 0 0", valid_cnt - vc0, fe_cnt - fe0);
    end
  endtask

  task automatic test_frame_err();
    int t0, base, bc0, fe0, ov0;
    base = got_q.size();
    bc0 = busy_cnt;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    drive_frame(8'h3C, 1'b0, 10, t0);
    idle(40);
    rx = 1'b1;
    idle(8);
    checks++;
    if (fe_cnt - fe0 !== 1) begin
      errors++;
      $display("FAIL ferr_pulses: got %0d, want 1", fe_cnt - fe0);
    end
    checks++;
    if ((got_q.size() !== base) || (out_valid !== 1'b0)) begin
      errors++;
      $display("FAIL ferr_no_byte: got %0d bytes valid=%b, want 0 0", got_q.size() - base, out_valid);
    end
    checks++;
    if (busy_cnt - bc0 !== BUSY_FRAME) begin
      errors++;
      $display("FAIL ferr_no_rearm: got busy %0d cycles, want %0d", busy_cnt - bc0, BUSY_FRAME);
    end
    checks++;
    if (ov_cnt - ov0 !== 0) begin
      errors++;
      $display("FAIL ferr_no_overrun: got %0d, want 0", ov_cnt - ov0);
    end
    drive_frame(8'h81, 1'b1, 10, t0);
    idle(6);
    checks++;
    if ((got_q.size() !== base + 1) || (got_q[got_q.size() - 1] !== 8'h81)) begin
      errors++;
      $display("FAIL ferr_recover: got %0d bytes last=%h, want 1 81",
               got_q.size() - base, got_q.size() > 0 ? got_q[got_q.size() - 1] : 8'hxx);
    end
  endtask

  task automatic test_overrun();
    int t0, base, ov0, fe0;
    base = got_q.size();
    ov0 = ov_cnt;
    fe0 = fe_cnt;
    out_ready = 1'b0;
    drive_frame(8'h3C, 1'b1, 10, t0);
    idle(2);
    drive_frame(8'hC3, 1'b1, 10, t0);
    idle(6);
    checks++;
    if ((out_valid !== 1'b1) || (out_data !== 8'h3C)) begin
      errors++;
      $display("FAIL ovr_hold: got valid=%b data=%h, want 1 3c", out_valid, out_data);
    end
    checks++;
    if ((ov_cnt - ov0 !== 1) || (fe_cnt - fe0 !== 0)) begin
      errors++;
      $display("FAIL ovr_pulse: got ov=%0d fe=%0d, want 1 0", ov_cnt - ov0, fe_cnt - fe0);
    end
    out_ready = 1'b1;
    idle(4);
    checks++;
    if ((got_q.size() !== base + 1) || (got_q[got_q.size() - 1] !== 8'h3C)) begin
      errors++;
      $display("FAIL ovr_handshake: got %0d bytes, want exactly one 3c", got_q.size() - base);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovr_drop: got valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_reset_midframe();
    int t0, base, fe0;
    out_ready = 1'b1;
    drive_frame(8'h5A, 1'b1, 5, t0);
    rx = 1'b1;
    idle(2);
    rst = 1'b1;
    #1;
    checks++;
    if ({out_data, out_valid, busy, frame_err, overrun} !== 12'h000) begin
      errors++;
      $display("FAIL rst_mid: got data=%h v=%b busy=%b fe=%b ov=%b, want all 0",
               out_data, out_valid, busy, frame_err, overrun);
    end
    idle(3);
    rst = 1'b0;
    idle(4);
    base = got_q.size();
    fe0 = fe_cnt;
    drive_frame(8'h55, 1'b1, 10, t0);
    idle(6);
    checks++;
    if ((got_q.size() !== base + 1) || (got_q[got_q.size() - 1] !== 8'h55) || (fe_cnt !== fe0)) begin
      errors++;
      $display("FAIL rst_recover: got %0d bytes fe=%0d, want one 55 no fe",
               got_q.size() - base, fe_cnt - fe0);
    end
  endtask

  // Reference: every frame with a high stop bit yields its byte in order; others count as frame errors.
  task automatic run_frames(input string name, input int n, input int gap_min, input int gap_max,
                            input bit allow_bad);
    logic [7:0] exp_q[$];
    int exp_fe, base, fe0, ov0, t0, gap;
    logic [7:0] b;
    logic stop;
    out_ready = 1'b1;
    base = got_q.size();
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    exp_fe = 0;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom_range(0, 255));
      stop = allow_bad ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (stop) exp_q.push_back(b);
      else exp_fe++;
      drive_frame(b, stop, 10, t0);
      rx = 1'b1;
      gap = $urandom_range(gap_min, gap_max);
      if (gap > 0) idle(gap);
    end
    idle(8);
    checks++;
    if (got_q.size() - base !== exp_q.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d bytes, want %0d", name, got_q.size() - base, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[base + i] !== exp_q[i]) begin
          errors++;
          $display("FAIL %s_data[%0d]: got %h, want %h", name, i, got_q[base + i], exp_q[i]);
        end
      end
    end
    checks++;
    if ((fe_cnt - fe0 !== exp_fe) || (ov_cnt - ov0 !== 0)) begin
      errors++;
      $display("FAIL %s_status: got fe=%0d ov=%0d, want %0d 0", name, fe_cnt - fe0, ov_cnt - ov0, exp_fe);
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_frame_a5();
    test_glitch();
    test_frame_err();
    test_overrun();
    run_frames("back_to_back", 4, 0, 0, 1'b0);
    run_frames("random", 16, 1, 8, 1'b1);
    test_reset_midframe();
    checks++;
    if (both_cnt !== 0) begin
      errors++;
      $display("FAIL fe_ov_exclusive: got %0d overlapping cycles, want 0", both_cnt);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
